// File: rtl/ex_alu_pkg.sv
// Shared execute-stage constants: datapath width, alu_op codes and br_type codes.
// The ALU control unit drives alu_op using these same codes.
package ex_alu_pkg;

   localparam int DW = 32;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_ADDU = 4'd8;
   localparam logic [3:0] ALU_SUBU = 4'd9;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_BEQ  = 3'd1;
   localparam logic [2:0] BR_BNE  = 3'd2;
   localparam logic [2:0] BR_BLT  = 3'd3;
   localparam logic [2:0] BR_BGT  = 3'd4;
   localparam logic [2:0] BR_BGE  = 3'd5;
   localparam logic [2:0] BR_BLE  = 3'd6;

endpackage

// File: rtl/ex_alu_core.sv
// Purely combinational ALU: result, zero, signed-overflow and illegal-op flags.
module alu_core
   import ex_alu_pkg::*;
#(
   parameter int W = ex_alu_pkg::DW
) (
   input  logic [3:0]   alu_op,
   input  logic [W-1:0] src_a,
   input  logic [W-1:0] src_b,
   input  logic [4:0]   shamt,
   output logic [W-1:0] result,
   output logic         zero,
   output logic         ovf,
   output logic         illegal_op
);

   logic [W-1:0] sum;
   logic [W-1:0] diff;

   assign sum  = src_a + src_b;
   assign diff = src_a - src_b;

   always_comb begin
      result     = '0;
      ovf        = 1'b0;
      illegal_op = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            result = sum;
            ovf    = (src_a[W-1] == src_b[W-1]) && (sum[W-1] != src_a[W-1]);
         end
         ALU_SUB: begin
            result = diff;
            ovf    = (src_a[W-1] != src_b[W-1]) && (diff[W-1] != src_a[W-1]);
         end
         ALU_AND:  result = src_a & src_b;
         ALU_OR:   result = src_a | src_b;
         ALU_XOR:  result = src_a ^ src_b;
         ALU_NOR:  result = ~(src_a | src_b);
         // Shifts operate on operand B only; operand A is ignored.
         ALU_SRL:  result = src_b >> shamt;
         ALU_SLL:  result = src_b << shamt;
         ALU_ADDU: result = sum;
         ALU_SUBU: result = diff;
         default:  illegal_op = 1'b1;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU core plus branch comparator, held in one output register
// behind a valid/ready handshake with flush.
module ex_alu_stage
   import ex_alu_pkg::*;
#(
   parameter int DW = ex_alu_pkg::DW,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    alu_op,
   input  logic [DW-1:0] src_a,
   input  logic [DW-1:0] src_b,
   input  logic [4:0]    shamt,
   input  logic [2:0]    br_type,
   input  logic [RW-1:0] in_rd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] result,
   output logic          zero,
   output logic          ovf,
   output logic          br_taken,
   output logic          illegal_op,
   output logic [RW-1:0] out_rd
);

   logic [DW-1:0] core_result;
   logic          core_zero;
   logic          core_ovf;
   logic          core_illegal;
   logic          br_cond;
   logic          capture;

   alu_core #(.W(DW)) u_core (
      .alu_op     (alu_op),
      .src_a      (src_a),
      .src_b      (src_b),
      .shamt      (shamt),
      .result     (core_result),
      .zero       (core_zero),
      .ovf        (core_ovf),
      .illegal_op (core_illegal)
   );

   // Branch decision uses the raw operands, independent of alu_op.
   always_comb begin
      br_cond = 1'b0;
      case (br_type)
         BR_BEQ:  br_cond = (src_a == src_b);
         BR_BNE:  br_cond = (src_a != src_b);
         BR_BLT:  br_cond = ($signed(src_a) <  $signed(src_b));
         BR_BGT:  br_cond = ($signed(src_a) >  $signed(src_b));
         BR_BGE:  br_cond = ($signed(src_a) >= $signed(src_b));
         BR_BLE:  br_cond = ($signed(src_a) <= $signed(src_b));
         default: br_cond = 1'b0;
      endcase
   end

   // Handshake: a transfer happens on an edge where valid && ready. in_ready
   // depends only on the output register (empty, or being drained this cycle),
   // never on in_valid. flush kills the held entry and any same-cycle capture.
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         result     <= '0;
         zero       <= 1'b0;
         ovf        <= 1'b0;
         br_taken   <= 1'b0;
         illegal_op <= 1'b0;
         out_rd     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid  <= 1'b1;
         result     <= core_result;
         zero       <= core_zero;
         ovf        <= core_ovf;
         br_taken   <= br_cond;
         illegal_op <= core_illegal;
         out_rd     <= in_rd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: reset, ALU ops, branches, stall, flush.
module tb_ex_alu_stage;
   import ex_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  shamt;
   logic [2:0]  br_type;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        ovf;
   logic        br_taken;
   logic        illegal_op;
   logic [4:0]  out_rd;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   ex_alu_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .shamt(shamt), .br_type(br_type),
      .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .ovf(ovf), .br_taken(br_taken), .illegal_op(illegal_op), .out_rd(out_rd)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [2:0] br, input logic [4:0] rd);
      in_valid = 1'b1;
      alu_op   = op;
      src_a    = a;
      src_b    = b;
      shamt    = sh;
      br_type  = br;
      in_rd    = rd;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(ALU_ADD, 32'd1, 32'd1, 5'd0, BR_BEQ, 5'd4);
      step(); step();
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {27'b0, zero, ovf, br_taken, illegal_op, 1'b0}, 32'd0);
      check("rst_rd", {27'b0, out_rd}, 32'd0);
      check("rst_ready", {31'b0, in_ready}, 32'd1);
      rst = 1'b0;

      drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, BR_NONE, 5'd3);
      step();
      check("add_valid", {31'b0, out_valid}, 32'd1);
      check("add_result", result, 32'h8000_0000);
      check("add_ovf", {31'b0, ovf}, 32'd1);
      check("add_zero", {31'b0, zero}, 32'd0);
      check("add_rd", {27'b0, out_rd}, 32'd3);

      drive(ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, BR_NONE, 5'd3);
      step();
      check("addu_result", result, 32'h8000_0000);
      check("addu_ovf", {31'b0, ovf}, 32'd0);

      drive(ALU_SUB, 32'h8000_0000, 32'd1, 5'd0, BR_NONE, 5'd1);
      step();
      check("sub_ovf_result", result, 32'h7FFF_FFFF);
      check("sub_ovf", {31'b0, ovf}, 32'd1);

      drive(ALU_SUB, 32'd5, 32'd5, 5'd0, BR_BEQ, 5'd2);
      step();
      check("sub_zero_result", result, 32'd0);
      check("sub_zero", {31'b0, zero}, 32'd1);
      check("beq_taken", {31'b0, br_taken}, 32'd1);

      drive(ALU_SUB, 32'hFFFF_FFFF, 32'd1, 5'd0, BR_BLT, 5'd2);
      step();
      check("sub_neg_result", result, 32'hFFFF_FFFE);
      check("sub_neg_ovf", {31'b0, ovf}, 32'd0);
      check("blt_taken", {31'b0, br_taken}, 32'd1);

      drive(ALU_SUB, 32'hFFFF_FFFF, 32'd1, 5'd0, BR_BGT, 5'd2);
      step();
      check("bgt_not_taken", {31'b0, br_taken}, 32'd0);

      drive(ALU_AND, 32'd5, 32'd5, 5'd0, BR_BGE, 5'd2);
      step();
      check("bge_equal", {31'b0, br_taken}, 32'd1);
      drive(ALU_AND, 32'd5, 32'hFFFF_FFFF, 5'd0, BR_BLE, 5'd2);
      step();
      check("ble_not_taken", {31'b0, br_taken}, 32'd0);
      drive(ALU_AND, 32'd5, 32'd5, 5'd0, BR_BNE, 5'd2);
      step();
      check("bne_equal", {31'b0, br_taken}, 32'd0);
      drive(ALU_AND, 32'd5, 32'd6, 5'd0, 3'd7, 5'd2);
      step();
      check("br_reserved", {31'b0, br_taken}, 32'd0);

      drive(ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, BR_NONE, 5'd6);
      step();
      check("and", result, 32'h00F0_000F);
      drive(ALU_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, BR_NONE, 5'd6);
      step();
      check("or", result, 32'hFFF0_0FFF);
      drive(ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, BR_NONE, 5'd6);
      step();
      check("xor", result, 32'hFF00_0FF0);
      drive(ALU_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, BR_NONE, 5'd6);
      step();
      check("nor", result, 32'h000F_F000);

      drive(ALU_SLL, 32'hDEAD_BEEF, 32'd1, 5'd31, BR_NONE, 5'd8);
      step();
      check("sll31", result, 32'h8000_0000);
      drive(ALU_SRL, 32'hDEAD_BEEF, 32'h8000_0000, 5'd4, BR_NONE, 5'd8);
      step();
      check("srl4", result, 32'h0800_0000);
      drive(ALU_SLL, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, BR_NONE, 5'd8);
      step();
      check("sll0", result, 32'h1234_5678);

      drive(4'd12, 32'd7, 32'd9, 5'd0, BR_NONE, 5'd10);
      step();
      check("illegal_result", result, 32'd0);
      check("illegal_flag", {31'b0, illegal_op}, 32'd1);
      check("illegal_zero", {31'b0, zero}, 32'd1);
      check("illegal_valid", {31'b0, out_valid}, 32'd1);

      in_valid = 1'b0;
      step();
      check("drain_valid", {31'b0, out_valid}, 32'd0);

      // Stall: A held while B waits upstream.
      drive(ALU_ADD, 32'd10, 32'd20, 5'd0, BR_NONE, 5'd7);
      exp_q.push_back(32'd30);
      exp_q.push_back(32'd99);
      step();
      check("stall_a_result", result, exp_q[0]);
      out_ready = 1'b0;
      drive(ALU_SUB, 32'd100, 32'd1, 5'd0, BR_NONE, 5'd9);
      #1;
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold_result", result, exp_q[0]);
         check("stall_hold_rd", {27'b0, out_rd}, 32'd7);
         check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
      end
      void'(exp_q.pop_front());
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      check("stall_b_result", result, exp_q.pop_front());
      check("stall_b_rd", {27'b0, out_rd}, 32'd9);
      check("stall_b_valid", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b0;
      step();
      check("stall_drain", {31'b0, out_valid}, 32'd0);

      // Flush during capture, then flush while stalled.
      drive(ALU_ADD, 32'd1, 32'd1, 5'd0, BR_NONE, 5'd5);
      flush = 1'b1;
      step();
      check("flush_capture_valid", {31'b0, out_valid}, 32'd0);
      flush = 1'b0;
      step();
      check("post_flush_valid", {31'b0, out_valid}, 32'd1);
      check("post_flush_result", result, 32'd2);
      out_ready = 1'b0;
      drive(ALU_OR, 32'd3, 32'd4, 5'd0, BR_NONE, 5'd6);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_stall_valid", {31'b0, out_valid}, 32'd0);
      check("flush_stall_ready", {31'b0, in_ready}, 32'd1);

      // Reset mid-operation discards the held entry.
      drive(ALU_ADD, 32'd4, 32'd4, 5'd0, BR_NONE, 5'd11);
      step();
      check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_rd", {27'b0, out_rd}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute-stage ALU, directly downstream of the ALU control unit. Consumes the 4-bit alu_op code together with the operands and branch type from the ID/EX path.
- Computes the 32-bit result, flags and branch decision, and holds them in a single output pipeline register.
- Uses a valid/ready handshake with flush so the pipeline can stall or kill the instruction in flight.

Parameters:
- DW, 32, datapath width in bits.
- RW, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill the instruction held or being captured (branch mispredict).
- in_valid  in  1  upstream presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 srl, 7 sll, 8 addu, 9 subu, 10-15 illegal.
- src_a  in  DW  operand A (rs).
- src_b  in  DW  operand B (rt or sign-extended immediate).
- shamt  in  5  shift amount for sll/srl.
- br_type  in  3  0 none, 1 beq, 2 bne, 3 blt, 4 bgt, 5 bge, 6 ble, 7 reserved (treated as none).
- in_rd  in  RW  destination register index.
- out_valid  out  1  output register holds a valid result.
- out_ready  in  1  downstream (MEM stage) accepts this cycle.
- result  out  DW  registered ALU result.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow, ops 0 and 1 only.
- br_taken  out  1  branch condition true.
- illegal_op  out  1  alu_op was in 10-15.
- out_rd  out  RW  registered destination index.

Behaviour:
- Reset: on the first clk edge with rst=1, out_valid, result, zero, ovf, br_taken, illegal_op and out_rd all clear to 0. rst overrides flush and in_valid. Reset mid-operation discards the held entry.
- in_ready = !out_valid || out_ready. This is combinational, not a function of in_valid, and is 1 while rst is held.
- Capture: when in_valid && in_ready && !flush, the output register loads the new result and flags, and out_valid is set to 1 on the next edge. Latency is exactly 1 cycle.
- Drain: when out_valid && out_ready && !(in_valid && in_ready), out_valid is set to 0.
- Stall: when out_valid && !out_ready, every output holds its value bit-for-bit.
- Flush: out_valid is set to 0 next edge and any simultaneous capture is dropped. Data outputs may keep stale values.
- Arithmetic:
  - add/addu compute a+b mod 2^DW; sub/subu compute a-b mod 2^DW.
  - ovf for add = sign(a)==sign(b) && sign(res)!=sign(a).
  - ovf for sub = sign(a)!=sign(b) && sign(res)!=sign(a).
  - ovf = 0 for all other ops.
- Logic ops are bitwise. nor = ~(a|b).
- Shifts: sll = b<<shamt, srl = b>>shamt (logical, zero-fill). shamt=0 passes b unchanged. src_a is ignored.
- Illegal op (10-15): result=0, zero=1, illegal_op=1, ovf=0. Handshake is unaffected.
- Branch:
  - br_taken is computed from src_a/src_b directly, independent of alu_op.
  - beq a==b; bne a!=b.
  - blt/bgt/bge/ble use signed compare (a<b, a>b, a>=b, a<=b).
  - br_type 0 or 7 gives br_taken=0.
- Simultaneous drain and capture in the same cycle: the new entry loads and out_valid stays 1 (back-to-back throughput of 1/cycle).

Decomposition:
- Shared package holds the alu_op code constants (ALU_ADD..ALU_SUBU), br_type constants (BR_NONE..BR_BLE) and DW. The ALU control unit uses the same alu_op constants.
- Sub-module alu_core is a purely combinational result/zero/ovf/illegal_op calculator. ex_alu_stage wraps it with the branch comparator and the handshake register.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> all outputs 0, in_ready=1.
- Arithmetic: alu_op=0, a=32'h7FFFFFFF, b=1, out_ready=1 -> next cycle result=32'h80000000, ovf=1, zero=0. Same operands with alu_op=8 -> ovf=0.
- Subtract and branch: alu_op=1, a=b=32'd5, br_type=1 -> result=0, zero=1, br_taken=1. With a=-1, b=1, br_type=3 (blt) -> br_taken=1. With br_type=4 -> br_taken=0.
- Shift and illegal op: alu_op=7, b=1, shamt=31 -> result=32'h80000000. alu_op=6, b=32'h80000000, shamt=4 -> 32'h08000000. alu_op=12 -> result=0, illegal_op=1.
- Stall: capture op A, hold out_ready=0 for 3 cycles while presenting op B -> in_ready=0, outputs hold A. Raise out_ready -> B appears the next cycle with out_valid held at 1.
- Flush: capture with flush=1 -> out_valid=0 next cycle. Flush while stalled -> out_valid=0 and in_ready=1 the following cycle.
